// File: rtl/kb_pkg.sv
// Scan-code, ASCII and decoder-state constants shared by the keyboard ASCII path.
package kb_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

endpackage

// File: rtl/key2ascii_shift.sv
// Scan code (set 2) to ASCII lookup with Shift/Caps handling; 8'h00 means unmapped.
// Purely combinational, no latency, no flow control.
module key2ascii_shift (
    input  logic [7:0] key_code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] base;
    logic [7:0] shifted;
    logic       is_alpha;

    always_comb begin
        base     = 8'h00;
        shifted  = 8'h00;
        is_alpha = 1'b0;
        case (key_code)
            8'h1C: begin base = "a"; is_alpha = 1'b1; end
            8'h32: begin base = "b"; is_alpha = 1'b1; end
            8'h21: begin base = "c"; is_alpha = 1'b1; end
            8'h23: begin base = "d"; is_alpha = 1'b1; end
            8'h24: begin base = "e"; is_alpha = 1'b1; end
            8'h2B: begin base = "f"; is_alpha = 1'b1; end
            8'h34: begin base = "g"; is_alpha = 1'b1; end
            8'h33: begin base = "h"; is_alpha = 1'b1; end
            8'h43: begin base = "i"; is_alpha = 1'b1; end
            8'h3B: begin base = "j"; is_alpha = 1'b1; end
            8'h42: begin base = "k"; is_alpha = 1'b1; end
            8'h4B: begin base = "l"; is_alpha = 1'b1; end
            8'h3A: begin base = "m"; is_alpha = 1'b1; end
            8'h31: begin base = "n"; is_alpha = 1'b1; end
            8'h44: begin base = "o"; is_alpha = 1'b1; end
            8'h4D: begin base = "p"; is_alpha = 1'b1; end
            8'h15: begin base = "q"; is_alpha = 1'b1; end
            8'h2D: begin base = "r"; is_alpha = 1'b1; end
            8'h1B: begin base = "s"; is_alpha = 1'b1; end
            8'h2C: begin base = "t"; is_alpha = 1'b1; end
            8'h3C: begin base = "u"; is_alpha = 1'b1; end
            8'h2A: begin base = "v"; is_alpha = 1'b1; end
            8'h1D: begin base = "w"; is_alpha = 1'b1; end
            8'h22: begin base = "x"; is_alpha = 1'b1; end
            8'h35: begin base = "y"; is_alpha = 1'b1; end
            8'h1A: begin base = "z"; is_alpha = 1'b1; end
            8'h16: {base, shifted} = {"1", "!"};
            8'h1E: {base, shifted} = {"2", "@"};
            8'h26: {base, shifted} = {"3", "#"};
            8'h25: {base, shifted} = {"4", "$"};
            8'h2E: {base, shifted} = {"5", "%"};
            8'h36: {base, shifted} = {"6", "^"};
            8'h3D: {base, shifted} = {"7", "&"};
            8'h3E: {base, shifted} = {"8", "*"};
            8'h46: {base, shifted} = {"9", "("};
            8'h45: {base, shifted} = {"0", ")"};
            8'h0E: {base, shifted} = {8'h60, "~"};
            8'h4E: {base, shifted} = {"-", "_"};
            8'h55: {base, shifted} = {"=", "+"};
            8'h54: {base, shifted} = {"[", "{"};
            8'h5B: {base, shifted} = {"]", "}"};
            8'h5D: {base, shifted} = {"\\", "|"};
            8'h4C: {base, shifted} = {";", ":"};
            8'h52: {base, shifted} = {"'", "\""};
            8'h41: {base, shifted} = {",", "<"};
            8'h49: {base, shifted} = {".", ">"};
            8'h4A: {base, shifted} = {"/", "?"};
            8'h5A: {base, shifted} = {8'h0D, 8'h0D};
            8'h29: {base, shifted} = {8'h20, 8'h20};
            8'h66: {base, shifted} = {8'h08, 8'h08};
            default: ;
        endcase

        if (is_alpha)
            ascii = (shift ^ caps) ? (base - 8'h20) : base;
        else
            ascii = shift ? shifted : base;
    end

endmodule

// File: rtl/kb_ascii_stream.sv
// PS/2 scan bytes -> make/break/extended decode -> case-correct ASCII into a show-ahead FIFO.
// Char written one clk after its scan tick (LF of CR+LF one clk later).
// No input backpressure: chars that do not fit are dropped and flagged sticky in overflow.
module kb_ascii_stream
    import kb_pkg::*;
#(
    parameter int FIFO_ADDR_W  = 4,
    parameter bit CRLF_EN      = 1'b1,
    parameter bit TYPEMATIC_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_code,
    input  logic       rd_ascii,
    output logic [7:0] ascii_out,
    output logic       buf_empty,
    output logic       buf_full,
    output logic       overflow,
    output logic       shift_on,
    output logic       caps_on
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CW    = FIFO_ADDR_W + 2;

    dec_state_t             state;
    logic                   shift_l;
    logic                   shift_r;
    logic                   caps_held;
    logic [7:0]             last_make;
    logic                   pending_lf;
    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr;
    logic [FIFO_ADDR_W-1:0] rd_ptr;
    logic [FIFO_ADDR_W:0]   count;

    logic [7:0]  lut;
    logic        is_mod;
    logic        new_vld;
    logic        want_lf;
    logic        pop;
    logic        accept;
    logic [CW-1:0] free;
    logic [CW-1:0] need;

    key2ascii_shift u_lut (
        .key_code (scan_code),
        .shift    (shift_on),
        .caps     (caps_on),
        .ascii    (lut)
    );

    assign shift_on  = shift_l | shift_r;
    assign buf_empty = (count == '0);
    assign buf_full  = (count == (FIFO_ADDR_W+1)'(DEPTH));
    assign ascii_out = buf_empty ? 8'h00 : mem[rd_ptr];

    always_comb begin
        is_mod  = (scan_code == SC_BREAK) || (scan_code == SC_EXT) ||
                  (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) ||
                  (scan_code == SC_CAPS);
        // Keypad Enter bypasses the repeat filter: its break never reaches last_make.
        new_vld = scan_done_tick && (lut != 8'h00) &&
                  (((state == ST_IDLE) && !is_mod && (TYPEMATIC_EN || (scan_code != last_make))) ||
                   ((state == ST_EXT) && (scan_code == SC_ENTER)));
        want_lf = CRLF_EN && (lut == ASC_CR);
        pop     = rd_ascii && !buf_empty;
        // A pending LF already owns one slot.
        free    = CW'(DEPTH) - CW'(count) + CW'(pop) - CW'(pending_lf);
        need    = want_lf ? CW'(2) : CW'(1);
        accept  = new_vld && (free >= need);
    end

    always_ff @(posedge clk) begin
        if (pending_lf) begin
            mem[wr_ptr] <= ASC_LF;
            if (accept)
                mem[wr_ptr + FIFO_ADDR_W'(1)] <= lut;
        end else if (accept) begin
            mem[wr_ptr] <= lut;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending_lf <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + FIFO_ADDR_W'(pending_lf) + FIFO_ADDR_W'(accept);
            rd_ptr     <= rd_ptr + FIFO_ADDR_W'(pop);
            count      <= count + (FIFO_ADDR_W+1)'(pending_lf) + (FIFO_ADDR_W+1)'(accept)
                                - (FIFO_ADDR_W+1)'(pop);
            pending_lf <= accept && want_lf;
            if (new_vld && !accept)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_on   <= 1'b0;
            caps_held <= 1'b0;
            last_make <= 8'h00;
        end else if (scan_done_tick) begin
            case (state)
                ST_IDLE: begin
                    case (scan_code)
                        SC_BREAK:  state   <= ST_BRK;
                        SC_EXT:    state   <= ST_EXT;
                        SC_LSHIFT: shift_l <= 1'b1;
                        SC_RSHIFT: shift_r <= 1'b1;
                        SC_CAPS: begin
                            if (!caps_held)
                                caps_on <= ~caps_on;
                            caps_held <= 1'b1;
                        end
                        default:   last_make <= scan_code;
                    endcase
                end
                ST_BRK: begin
                    state <= ST_IDLE;
                    case (scan_code)
                        SC_LSHIFT: shift_l   <= 1'b0;
                        SC_RSHIFT: shift_r   <= 1'b0;
                        SC_CAPS:   caps_held <= 1'b0;
                        default: ;
                    endcase
                    if (scan_code == last_make)
                        last_make <= 8'h00;
                end
                ST_EXT:     state <= (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_ascii_stream.sv
// Directed bench for kb_ascii_stream: defaults instance plus a TYPEMATIC_EN=1, CRLF_EN=0 instance.
module tb_kb_ascii_stream;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       rd_m = 1'b0;
    logic       rd_t = 1'b0;
    logic       typ_sel = 1'b0;
    logic       tick_t;

    logic [7:0] ascii_m, ascii_t;
    logic       empty_m, full_m, ovf_m, shift_m, caps_m;
    logic       empty_t, full_t, ovf_t, shift_t, caps_t;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign tick_t = tick & typ_sel;

    kb_ascii_stream dut (
        .clk            (clk),
        .reset          (reset),
        .scan_done_tick (tick),
        .scan_code      (scan_code),
        .rd_ascii       (rd_m),
        .ascii_out      (ascii_m),
        .buf_empty      (empty_m),
        .buf_full       (full_m),
        .overflow       (ovf_m),
        .shift_on       (shift_m),
        .caps_on        (caps_m)
    );

    kb_ascii_stream #(.FIFO_ADDR_W(4), .CRLF_EN(1'b0), .TYPEMATIC_EN(1'b1)) dut_t (
        .clk            (clk),
        .reset          (reset),
        .scan_done_tick (tick_t),
        .scan_code      (scan_code),
        .rd_ascii       (rd_t),
        .ascii_out      (ascii_t),
        .buf_empty      (empty_t),
        .buf_full       (full_t),
        .overflow       (ovf_t),
        .shift_on       (shift_t),
        .caps_on        (caps_t)
    );

    task automatic send(input logic [7:0] c);
        @(posedge clk); #1;
        scan_code = c;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic pop_m();
        rd_m = 1'b1;
        @(posedge clk); #1;
        rd_m = 1'b0;
    endtask

    task automatic pop_t();
        rd_t = 1'b1;
        @(posedge clk); #1;
        rd_t = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty_m !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty_m); else passes++;
        checks++; if (full_m !== 1'b0) $display("FAIL reset_full: got %b want 0", full_m); else passes++;
        checks++; if (ovf_m !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_m); else passes++;
        checks++; if (ascii_m !== 8'h00) $display("FAIL reset_ascii: got %h want 00", ascii_m); else passes++;
        checks++; if (shift_m !== 1'b0 || caps_m !== 1'b0)
            $display("FAIL reset_mods: got %b%b want 00", shift_m, caps_m); else passes++;
    endtask

    task automatic test_single();
        pop_m();
        checks++; if (empty_m !== 1'b1 || ascii_m !== 8'h00)
            $display("FAIL rd_on_empty: got %b/%h want 1/00", empty_m, ascii_m); else passes++;
        send(8'h1C);
        checks++; if (empty_m !== 1'b0 || ascii_m !== 8'h61)
            $display("FAIL single_latency: got %b/%h want 0/61", empty_m, ascii_m); else passes++;
        send(8'hF0); send(8'h1C);
        pop_m();
        checks++; if (empty_m !== 1'b1)
            $display("FAIL single_break_noenq: got empty=%b head=%h want 1", empty_m, ascii_m); else passes++;
    endtask

    task automatic test_shift();
        send(8'h12);
        checks++; if (shift_m !== 1'b1) $display("FAIL shift_held: got %b want 1", shift_m); else passes++;
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        checks++; if (shift_m !== 1'b0) $display("FAIL shift_release: got %b want 0", shift_m); else passes++;
        send(8'h16);
        checks++; if (ascii_m !== 8'h41) $display("FAIL shift_A: got %h want 41", ascii_m); else passes++;
        pop_m();
        checks++; if (ascii_m !== 8'h31) $display("FAIL shift_1: got %h want 31", ascii_m); else passes++;
        pop_m();
        checks++; if (empty_m !== 1'b1) $display("FAIL shift_drain: got %b want 1", empty_m); else passes++;
        send(8'hF0); send(8'h16);
    endtask

    task automatic test_caps();
        logic [7:0] exp [3];
        exp = '{8'h41, 8'h61, 8'h21};
        send(8'h58); send(8'hF0); send(8'h58);
        checks++; if (caps_m !== 1'b1) $display("FAIL caps_on: got %b want 1", caps_m); else passes++;
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h16); send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
        for (int i = 0; i < 3; i++) begin
            checks++; if (ascii_m !== exp[i] || empty_m !== 1'b0)
                $display("FAIL caps_entry%0d: got %h want %h", i, ascii_m, exp[i]); else passes++;
            pop_m();
        end
        checks++; if (empty_m !== 1'b1) $display("FAIL caps_drain: got %b want 1", empty_m); else passes++;
        send(8'h58);
        send(8'h58);
        send(8'hF0); send(8'h58);
        checks++; if (caps_m !== 1'b0) $display("FAIL caps_off_once: got %b want 0", caps_m); else passes++;
    endtask

    task automatic test_typematic();
        logic [7:0] exp_m [4];
        exp_m = '{8'h61, 8'h61, 8'h0D, 8'h0A};
        typ_sel = 1'b1;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'h5A); send(8'hF0); send(8'h5A);
        typ_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ascii_m !== exp_m[i] || empty_m !== 1'b0)
                $display("FAIL typ_off_entry%0d: got %h want %h", i, ascii_m, exp_m[i]); else passes++;
            pop_m();
        end
        checks++; if (empty_m !== 1'b1) $display("FAIL typ_off_count: got empty=%b want 1", empty_m); else passes++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ascii_t !== (i == 4 ? 8'h0D : 8'h61) || empty_t !== 1'b0)
                $display("FAIL typ_on_entry%0d: got %h want %h", i, ascii_t, (i == 4 ? 8'h0D : 8'h61)); else passes++;
            pop_t();
        end
        checks++; if (empty_t !== 1'b1) $display("FAIL typ_on_count: got empty=%b want 1", empty_t); else passes++;
    endtask

    task automatic test_enter();
        send(8'h5A);
        checks++; if (ascii_m !== 8'h0D) $display("FAIL enter_cr: got %h want 0D", ascii_m); else passes++;
        pop_m();
        checks++; if (ascii_m !== 8'h0A || empty_m !== 1'b0)
            $display("FAIL enter_lf: got %h/%b want 0A/0", ascii_m, empty_m); else passes++;
        pop_m();
        send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        checks++; if (empty_m !== 1'b1) $display("FAIL ext_nothing: got empty=%b head=%h want 1", empty_m, ascii_m); else passes++;
        send(8'hE0); send(8'h5A);
        checks++; if (ascii_m !== 8'h0D) $display("FAIL kp_enter_cr: got %h want 0D", ascii_m); else passes++;
        pop_m();
        checks++; if (ascii_m !== 8'h0A) $display("FAIL kp_enter_lf: got %h want 0A", ascii_m); else passes++;
        pop_m();
        checks++; if (empty_m !== 1'b1) $display("FAIL kp_enter_drain: got %b want 1", empty_m); else passes++;
        send(8'hE0); send(8'hF0); send(8'h5A);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send((i % 2) ? 8'h32 : 8'h1C);
        checks++; if (full_m !== 1'b1 || ovf_m !== 1'b0)
            $display("FAIL fill16: got full=%b ovf=%b want 1/0", full_m, ovf_m); else passes++;
        send(8'h1C);
        checks++; if (ovf_m !== 1'b1 || full_m !== 1'b1)
            $display("FAIL drop17: got ovf=%b full=%b want 1/1", ovf_m, full_m); else passes++;
        pop_m();
        send(8'h5A);
        @(posedge clk); #1;
        checks++; if (full_m !== 1'b0) $display("FAIL crlf_drop: got full=%b want 0", full_m); else passes++;
        send(8'h1C);
        checks++; if (full_m !== 1'b1) $display("FAIL refill16: got full=%b want 1", full_m); else passes++;
        @(posedge clk); #1;
        scan_code = 8'h32;
        tick = 1'b1;
        rd_m = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        rd_m = 1'b0;
        checks++; if (full_m !== 1'b1 || ascii_m !== 8'h61)
            $display("FAIL rw_on_full: got full=%b head=%h want 1/61", full_m, ascii_m); else passes++;
        for (int i = 0; i < 16; i++) begin
            checks++; if (ascii_m !== ((i % 2) ? 8'h62 : 8'h61) || empty_m !== 1'b0)
                $display("FAIL drain%0d: got %h want %h", i, ascii_m, ((i % 2) ? 8'h62 : 8'h61)); else passes++;
            pop_m();
        end
        checks++; if (empty_m !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty_m); else passes++;
    endtask

    task automatic test_reset_mid();
        send(8'hF0);
        do_reset();
        checks++; if (ovf_m !== 1'b0 || empty_m !== 1'b1)
            $display("FAIL midreset_clear: got ovf=%b empty=%b want 0/1", ovf_m, empty_m); else passes++;
        send(8'h1C);
        checks++; if (ascii_m !== 8'h61 || empty_m !== 1'b0)
            $display("FAIL midreset_prefix: got %h/%b want 61/0", ascii_m, empty_m); else passes++;
        pop_m();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_shift();
        test_caps();
        test_typematic();
        test_enter();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
